// File: rtl/stream_mux_rr_if.sv
// Valid/ready bundle for the round-robin stream mux: NUM_IN producer lanes in,
// one tagged consumer lane out. The mux takes the slave side; the environment drives master.
interface stream_mux_rr_if #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 3,
  parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-input stream multiplexer with an internal arbiter (round-robin or fixed priority)
// feeding a 1-deep registered output buffer; out_sel tags the source channel.
module stream_mux_rr #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 3,
  parameter int MODE   = 0
) (
  input  logic            clk,
  input  logic            rst,
  stream_mux_rr_if.slave  bus
);
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   grant;
  logic               any;
  logic               load;

  assign any  = |bus.in_valid;
  assign load = (state_q == EMPTY) | bus.out_ready;

  // Search starts at ptr and wraps; in fixed-priority mode ptr stays 0,
  // which turns the same search into lowest-index-wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    grant = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (bus.in_valid[idx]) grant = SEL_W'(idx);
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (!rst && load && any) bus.in_ready[grant] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (any) begin
        state_d = FULL;
        data_d  = bus.in_data[grant*WIDTH +: WIDTH];
        sel_d   = grant;
        if (MODE == 0)
          ptr_d = (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + SEL_W'(1);
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a round-robin instance checked through a
// scoreboard of expected output words, plus a fixed-priority instance.
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.NUM_IN(4), .WIDTH(3)) bus_a ();
  stream_mux_rr_if #(.NUM_IN(4), .WIDTH(3)) bus_b ();

  stream_mux_rr #(.NUM_IN(4), .WIDTH(3), .MODE(0)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  stream_mux_rr #(.NUM_IN(4), .WIDTH(3), .MODE(1)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  typedef struct packed {
    logic [2:0] data;
    logic [1:0] sel;
  } sb_entry_t;

  sb_entry_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] data, input logic [1:0] sel);
    sb.push_back('{data: data, sel: sel});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output transfers happen at the next rising edge; score them mid-cycle.
  always @(negedge clk) begin
    if (!rst && bus_a.out_valid && bus_a.out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_pop: unexpected word data=%0h sel=%0h, expected none",
               bus_a.out_data, bus_a.out_sel);
      end
      if (sb.size() != 0) begin
        sb_entry_t e;
        e = sb.pop_front();
        check("sb_data", 32'(bus_a.out_data), 32'(e.data));
        check("sb_sel",  32'(bus_a.out_sel),  32'(e.sel));
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus_a.in_data  = {3'd3, 3'd2, 3'd1, 3'd0};
    bus_a.in_valid = 4'b1111;
    bus_a.out_ready = 1'b1;
    bus_b.in_data  = {3'd3, 3'd2, 3'd1, 3'd0};
    bus_b.in_valid = 4'b0000;
    bus_b.out_ready = 1'b1;

    // Reset held for two edges with every channel requesting.
    tick();
    tick();
    check("rst_in_ready",  32'(bus_a.in_ready),  32'h0);
    check("rst_out_valid", 32'(bus_a.out_valid), 32'h0);
    check("rst_out_data",  32'(bus_a.out_data),  32'h0);
    check("rst_out_sel",   32'(bus_a.out_sel),   32'h0);
    check("rst_fp_valid",  32'(bus_b.out_valid), 32'h0);

    // Round-robin with all channels valid: 0,1,2,3,0,1 back to back.
    rst = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      check("rr_in_ready", 32'(bus_a.in_ready), 32'(4'b0001 << (k % 4)));
      push(3'(k % 4), 2'(k % 4));
      tick();
      check("rr_out_sel",  32'(bus_a.out_sel),  32'(k % 4));
      check("rr_out_data", 32'(bus_a.out_data), 32'(k % 4));
    end

    // Single source on channel 2 while the previous word drains.
    bus_a.in_valid = 4'b0100;
    #1;
    check("single_in_ready", 32'(bus_a.in_ready), 32'h4);
    push(3'b010, 2'd2);
    tick();
    bus_a.in_valid = 4'b0000;
    check("single_out_valid", 32'(bus_a.out_valid), 32'h1);
    check("single_out_data",  32'(bus_a.out_data),  32'h2);
    check("single_out_sel",   32'(bus_a.out_sel),   32'h2);

    // Pointer now at 3; only channel 0 requests, so the search wraps.
    bus_a.in_valid = 4'b0001;
    #1;
    check("wrap_in_ready", 32'(bus_a.in_ready), 32'h1);
    push(3'd0, 2'd0);
    tick();
    bus_a.in_valid = 4'b0000;
    check("wrap_out_sel", 32'(bus_a.out_sel), 32'h0);
    tick();
    check("idle_out_valid", 32'(bus_a.out_valid), 32'h0);

    // Backpressure: pointer at 1, load a word from channel 1, then stall.
    bus_a.in_valid  = 4'b1111;
    bus_a.out_ready = 1'b0;
    #1;
    check("bp_load_in_ready", 32'(bus_a.in_ready), 32'h2);
    push(3'd1, 2'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready",  32'(bus_a.in_ready),  32'h0);
      check("bp_out_valid", 32'(bus_a.out_valid), 32'h1);
      check("bp_out_sel",   32'(bus_a.out_sel),   32'h1);
      check("bp_out_data",  32'(bus_a.out_data),  32'h1);
      tick();
    end
    bus_a.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus_a.in_ready), 32'h4);
    push(3'd2, 2'd2);
    tick();
    bus_a.in_valid = 4'b0000;
    check("bp_next_sel", 32'(bus_a.out_sel), 32'h2);

    // Reset while a word is held under backpressure: the word is discarded.
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 4'b1111;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_in_ready", 32'(bus_a.in_ready), 32'h0);
    tick();
    check("midrst_out_valid", 32'(bus_a.out_valid), 32'h0);
    rst = 1'b0;
    #1;
    check("postrst_in_ready", 32'(bus_a.in_ready), 32'h1);
    push(3'd0, 2'd0);
    tick();
    check("postrst_out_sel", 32'(bus_a.out_sel), 32'h0);
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 4'b0000;
    tick();
    check("postrst_drained", 32'(bus_a.out_valid), 32'h0);

    // Fixed priority instance: channel 0 always wins while it requests.
    bus_b.in_valid = 4'b1111;
    #1;
    check("fp_in_ready", 32'(bus_b.in_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fp_out_sel",       32'(bus_b.out_sel),  32'h0);
      check("fp_hold_in_ready", 32'(bus_b.in_ready), 32'h1);
    end
    bus_b.in_valid = 4'b1110;
    #1;
    check("fp_ch1_in_ready", 32'(bus_b.in_ready), 32'h2);
    tick();
    bus_b.in_valid = 4'b0000;
    check("fp_ch1_out_sel",  32'(bus_b.out_sel),  32'h1);
    check("fp_ch1_out_data", 32'(bus_b.out_data), 32'h1);

    tick();
    tick();
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
